// File: rtl/result_display_if.sv
// Result hand-off from the ALU plus the multiplexed seven-segment pins of the display driver.
interface result_display_if;
  logic [13:0] value_in;
  logic        neg_in;
  logic        load;
  logic        busy;
  logic        done;
  logic [3:0]  an;
  logic [6:0]  seg;

  modport master (output value_in, neg_in, load, input busy, done, an, seg);
  modport slave  (input value_in, neg_in, load, output busy, done, an, seg);
endinterface

// File: rtl/result_display_driver.sv
// Sequential double-dabble of a signed calculator result and a multiplexed 4-digit,
// active-low seven-segment driver with leading-zero blanking, minus sign and "Err".
module result_display_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst,
  result_display_if.slave  bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  localparam int DW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [1:0]    state_reg;
  logic [13:0]   val_reg;
  logic [13:0]   bin_reg;
  logic [15:0]   bcd_reg;
  logic          neg_reg;
  logic [3:0]    cnt_reg;
  logic          busy_reg;
  logic          done_reg;
  logic [6:0]    disp_reg [4];
  logic [DW-1:0] div_reg;
  logic [1:0]    idx_reg;
  logic [3:0]    an_reg;
  logic [6:0]    seg_reg;

  logic [15:0]   bcd_adj;
  logic [1:0]    msd;
  logic          err;
  logic [6:0]    base_seg  [4];
  logic [6:0]    disp_next [4];

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = SEG_BLANK;
    endcase
  endfunction

  // Double-dabble correction of each BCD nibble before the shift.
  for (genvar gi = 0; gi < 4; gi++) begin : g_adj
    assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
    assign base_seg[gi] = (2'(gi) <= msd) ? glyph(bcd_reg[gi*4 +: 4]) : SEG_BLANK;
  end

  // Most significant non-zero digit; units always counts as shown.
  always_comb begin
    msd = 2'd0;
    if (bcd_reg[7:4]   != 4'd0) msd = 2'd1;
    if (bcd_reg[11:8]  != 4'd0) msd = 2'd2;
    if (bcd_reg[15:12] != 4'd0) msd = 2'd3;
  end

  assign err = (val_reg > 14'd9999) || (neg_reg && (val_reg > 14'd999));

  always_comb begin
    for (int i = 0; i < 4; i++) disp_next[i] = base_seg[i];
    if (neg_reg && (val_reg != 14'd0) && (msd != 2'd3))
      disp_next[msd + 2'd1] = SEG_MINUS;
    if (err) begin
      disp_next[3] = SEG_BLANK;
      disp_next[2] = SEG_E;
      disp_next[1] = SEG_R;
      disp_next[0] = SEG_R;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      val_reg   <= '0;
      bin_reg   <= '0;
      bcd_reg   <= '0;
      neg_reg   <= 1'b0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      disp_reg[0] <= SEG_ZERO;
      disp_reg[1] <= SEG_BLANK;
      disp_reg[2] <= SEG_BLANK;
      disp_reg[3] <= SEG_BLANK;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.load) begin
            val_reg   <= bus.value_in;
            bin_reg   <= bus.value_in;
            neg_reg   <= bus.neg_in;
            bcd_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd_reg, bin_reg} <= {bcd_adj, bin_reg} << 1;
          if (cnt_reg == 4'd13) state_reg <= COMMIT;
          else                  cnt_reg   <= cnt_reg + 4'd1;
        end
        COMMIT: begin
          for (int i = 0; i < 4; i++) disp_reg[i] <= disp_next[i];
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Digit scan: an/seg follow idx one clock later so both change on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg <= '0;
      idx_reg <= 2'd0;
      an_reg  <= 4'b1110;
      seg_reg <= SEG_ZERO;
    end else begin
      if (div_reg == DW'(REFRESH_DIV - 1)) begin
        div_reg <= '0;
        idx_reg <= idx_reg + 2'd1;
      end else begin
        div_reg <= div_reg + 1'b1;
      end
      an_reg  <= ~(4'b0001 << idx_reg);
      seg_reg <= disp_reg[idx_reg];
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.an   = an_reg;
  assign bus.seg  = seg_reg;
endmodule
